// File: rtl/mem_access_pkg.sv
// Shared encodings and types for the load/store access unit.
package mem_access_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   // Wait counter covers the full 0..15 range of extra window cycles.
   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp,
      StErr
   } state_e;

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake and RAM port bundle between the pipeline and the access unit.
interface mem_access_if #(
   parameter int unsigned ADDR_W = 9
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;

   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_error;

   logic              mem_enable;
   logic              mem_read_write;
   logic              mem_sign_extend;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_data_in;
   logic [31:0]       mem_data_out;

   // Pipeline / RAM environment side.
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
      input  req_ready, resp_valid, resp_data, resp_error,
      input  mem_enable, mem_read_write, mem_sign_extend, mem_size, mem_address, mem_data_in
   );

   // Access unit side.
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
      output req_ready, resp_valid, resp_data, resp_error,
      output mem_enable, mem_read_write, mem_sign_extend, mem_size, mem_address, mem_data_in
   );

endinterface

// File: rtl/mem_align_check.sv
// Size/alignment legality check and low-bit address alignment.
// MEM_ACCESS_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module mem_align_check
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 9
) (
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   output logic              illegal,
   output logic [ADDR_W-1:0] aligned
);

   always_comb begin
      aligned = addr;
      case (size)
         SIZE_HALF: aligned[0]   = 1'b0;
         SIZE_WORD: aligned[1:0] = 2'b00;
         default:   ;
      endcase
   end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   always_comb begin
      illegal = (size == SIZE_ILLEGAL) ||
                ((size == SIZE_HALF) && addr[0]) ||
                ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
   end
`else
   // Low bits are silently cleared instead of trapping.
   always_comb begin
      illegal = (size == SIZE_ILLEGAL);
   end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store controller for the level-sensitive data RAM port.
// Build option MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word requests return an error.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = 9
) (
   input logic        clk,
   input logic        rst_n,
   mem_access_if.slave bus
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic                  sign_q, sign_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  en_q, en_d;
   logic                  rw_q, rw_d;
   logic                  ready_q, ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_error_q, resp_error_d;
   logic [31:0]           resp_data_q, resp_data_d;

   logic                  illegal;
   logic [ADDR_W-1:0]     aligned;
   logic                  accept;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

   mem_align_check #(
      .ADDR_W (ADDR_W)
   ) u_align (
      .size    (bus.req_size),
      .addr    (bus.req_addr[ADDR_W-1:0]),
      .illegal (illegal),
      .aligned (aligned)
   );

   assign accept = bus.req_valid & ready_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      size_d       = size_q;
      sign_d       = sign_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      en_d         = en_q;
      rw_d         = rw_q;
      ready_d      = ready_q;
      resp_valid_d = resp_valid_q;
      resp_error_d = resp_error_q;
      resp_data_d  = resp_data_q;

      unique case (state_q)
         StIdle: begin
            if (resp_valid_q) begin
               // Error pulse ends here; ready only rises after it.
               resp_valid_d = 1'b0;
               resp_error_d = 1'b0;
               ready_d      = 1'b1;
            end else if (accept) begin
               write_d = bus.req_write;
               size_d  = bus.req_size;
               sign_d  = bus.req_signed;
               addr_d  = aligned;
               wdata_d = bus.req_wdata;
               cnt_d   = '0;
               ready_d = 1'b0;
               if (illegal) begin
                  state_d = StErr;
               end else begin
                  state_d = StAccess;
                  en_d    = 1'b1;
                  rw_d    = bus.req_write;
               end
            end
         end
         StAccess: begin
            if (cnt_q == WAIT_LAST) begin
               state_d      = StResp;
               en_d         = 1'b0;
               rw_d         = 1'b0;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
               resp_data_d  = write_q ? '0 : bus.mem_data_out;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d      = StIdle;
            resp_valid_d = 1'b0;
            resp_data_d  = '0;
            ready_d      = 1'b1;
         end
         StErr: begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         sign_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         en_q         <= 1'b0;
         rw_q         <= 1'b0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         size_q       <= size_d;
         sign_q       <= sign_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         en_q         <= en_d;
         rw_q         <= rw_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign bus.req_ready       = ready_q;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_error      = resp_error_q;
   assign bus.resp_data       = resp_data_q;
   assign bus.mem_enable      = en_q;
   assign bus.mem_read_write  = rw_q;
   assign bus.mem_sign_extend = sign_q;
   assign bus.mem_size        = size_q;
   assign bus.mem_address     = addr_q;
   assign bus.mem_data_in     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a big-endian RAM model and byte-array reference.
module tb_mem_access_unit;

   localparam int unsigned W = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec     = 0;
   int   n_miscmp  = 0;
   int   rw_leak   = 0;

   mem_access_if #(.ADDR_W(9)) bus ();

   mem_access_unit #(
      .WAIT_CYCLES (W),
      .ADDR_W      (9)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Device-side RAM: 512 bytes, big-endian, does its own extension.
   logic [7:0] ram [0:511];
   int unsigned ref_mem [512];

   always @(posedge clk) begin
      if (bus.mem_enable && bus.mem_read_write) begin
         case (bus.mem_size)
            2'b00: ram[bus.mem_address] = bus.mem_data_in[7:0];
            2'b01: begin
               ram[bus.mem_address]        = bus.mem_data_in[15:8];
               ram[bus.mem_address + 9'd1] = bus.mem_data_in[7:0];
            end
            default: begin
               ram[bus.mem_address]        = bus.mem_data_in[31:24];
               ram[bus.mem_address + 9'd1] = bus.mem_data_in[23:16];
               ram[bus.mem_address + 9'd2] = bus.mem_data_in[15:8];
               ram[bus.mem_address + 9'd3] = bus.mem_data_in[7:0];
            end
         endcase
      end
   end

   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = ram[bus.mem_address];
      h = {ram[bus.mem_address], ram[bus.mem_address + 9'd1]};
      case (bus.mem_size)
         2'b00:   bus.mem_data_out = bus.mem_sign_extend ? {{24{b[7]}}, b} : {24'd0, b};
         2'b01:   bus.mem_data_out = bus.mem_sign_extend ? {{16{h[15]}}, h} : {16'd0, h};
         default: bus.mem_data_out = {h, ram[bus.mem_address + 9'd2], ram[bus.mem_address + 9'd3]};
      endcase
   end

   always @(negedge clk) begin
      if (bus.mem_read_write === 1'b1 && bus.mem_enable !== 1'b1) rw_leak++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miscmp++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int unsigned a, input logic [7:0] v);
      ram[a]     = v;
      ref_mem[a] = int'(v);
   endtask

   // Reference: what the request should return, from the byte array and the access rules.
   function automatic void model(input bit wr, input bit [1:0] sz, input bit sg,
                                 input int unsigned ad, input int unsigned wd,
                                 output bit err, output int unsigned ea, output int unsigned ed);
      int unsigned n, a;
      longint v;
      err = (sz == 2'd3);
      ea  = 0;
      ed  = 0;
      if (err) return;
      n = 1 << sz;
      a = ad % 512;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      if (a % n != 0) begin
         err = 1'b1;
         return;
      end
`endif
      a  = a - (a % n);
      ea = a;
      if (wr) begin
         for (int i = 0; i < int'(n); i++) ref_mem[a + i] = (wd >> (8 * (n - 1 - i))) & 255;
      end else begin
         v = 0;
         for (int i = 0; i < int'(n); i++) v = v * 256 + longint'(ref_mem[a + i]);
         if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
         ed = 32'(v);
      end
   endfunction

   task automatic do_req(input bit wr, input bit [1:0] sz, input bit sg, input logic [31:0] ad,
                         input logic [31:0] wd, output logic [31:0] got);
      bit          e_err;
      int unsigned e_addr, e_data;
      int          guard, en_cnt, resp_at;
      logic [8:0]  f_addr;
      logic [1:0]  f_size;
      logic        f_sign, f_rw, moved, nxt_ready, nxt_valid, got_err;
      logic [31:0] f_din;
      model(wr, sz, sg, ad, wd, e_err, e_addr, e_data);
      guard = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = ad;
      bus.req_wdata  = wd;
      @(posedge clk);
      en_cnt = 0; resp_at = 0; moved = 1'b0; got = 'x; got_err = 1'bx;
      nxt_ready = 1'bx; nxt_valid = 1'bx;
      f_addr = 'x; f_size = 'x; f_sign = 1'bx; f_rw = 1'bx; f_din = 'x;
      for (int c = 1; c <= int'(W) + 5; c++) begin
         @(negedge clk);
         if (bus.mem_enable === 1'b1) begin
            if (en_cnt == 0) begin
               f_addr = bus.mem_address; f_size = bus.mem_size; f_sign = bus.mem_sign_extend;
               f_rw = bus.mem_read_write; f_din = bus.mem_data_in;
            end else if ({f_addr, f_size, f_sign, f_rw, f_din} !==
                         {bus.mem_address, bus.mem_size, bus.mem_sign_extend,
                          bus.mem_read_write, bus.mem_data_in}) begin
               moved = 1'b1;
            end
            en_cnt++;
         end
         if (bus.resp_valid === 1'b1 && resp_at == 0) begin
            resp_at = c;
            got     = bus.resp_data;
            got_err = bus.resp_error;
         end else if (resp_at != 0 && c == resp_at + 1) begin
            nxt_ready = bus.req_ready;
            nxt_valid = bus.resp_valid;
         end
         if (c == 1) begin
            // Scramble the request lines: the RAM side must not follow them.
            bus.req_valid = 1'b0; bus.req_addr = ~ad; bus.req_wdata = ~wd;
            bus.req_size = ~sz; bus.req_write = ~wr; bus.req_signed = ~sg;
         end
      end
      chk("resp_latency", 32'(resp_at), e_err ? 32'd2 : 32'(W + 2));
      chk("enable_cycles", 32'(en_cnt), e_err ? 32'd0 : 32'(W + 1));
      chk("resp_error", 32'(got_err), 32'(e_err));
      chk("resp_data", got, e_err ? 32'd0 : e_data);
      chk("resp_pulse_width", 32'(nxt_valid), 32'd0);
      chk("ready_after_resp", 32'(nxt_ready), 32'd1);
      if (!e_err) begin
         chk("mem_address", 32'(f_addr), e_addr);
         chk("mem_size", 32'(f_size), 32'(sz));
         chk("mem_sign_extend", 32'(f_sign), 32'(sg));
         chk("mem_read_write", 32'(f_rw), 32'(wr));
         chk("window_stable", 32'(moved), 32'd0);
         if (wr) chk("mem_data_in", f_din, wd);
      end
   endtask

   initial begin
      logic [31:0] got;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      for (int i = 0; i < 512; i++) poke(i, 8'($urandom));
      poke(16, 8'hDE); poke(17, 8'hAD); poke(18, 8'hBE); poke(19, 8'hEF);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_address", 32'(bus.mem_address), 32'd0);

      // Directed loads
      do_req(1'b0, 2'b10, 1'b0, 32'd16, 32'd0, got);
      chk("word_load_16", got, 32'hDEADBEEF);
      do_req(1'b0, 2'b00, 1'b1, 32'd17, 32'd0, got);
      chk("byte_load_signed", got, 32'hFFFFFFAD);
      do_req(1'b0, 2'b00, 1'b0, 32'd17, 32'd0, got);
      chk("byte_load_unsigned", got, 32'h000000AD);

      // Half store then word readback
      do_req(1'b1, 2'b01, 1'b0, 32'd40, 32'h0000_1234, got);
      do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'd0, got);
      chk("half_store_readback", 32'(got[31:16]), 32'h1234);

      // Misaligned word near top of RAM, upper address bits ignored
      do_req(1'b0, 2'b10, 1'b0, 32'hABCD_01F2, 32'd0, got);
      do_req(1'b0, 2'b01, 1'b1, 32'd41, 32'd0, got);

      // Illegal size with ReqValid held through the response
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b11;
      bus.req_signed = 1'b0; bus.req_addr = 32'd5;
      @(posedge clk);
      for (int c = 1; c <= int'(W) + 5; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.req_size = 2'b10; bus.req_addr = 32'd16;
            chk("hold_ready_c1", 32'(bus.req_ready), 32'd0);
         end
         if (c == 2) begin
            chk("hold_err_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_err_flag", 32'(bus.resp_error), 32'd1);
            chk("hold_err_data", bus.resp_data, 32'd0);
            chk("hold_ready_c2", 32'(bus.req_ready), 32'd0);
         end
         if (c <= 3) chk("hold_no_enable", 32'(bus.mem_enable), 32'd0);
         if (c == 3) chk("hold_ready_c3", 32'(bus.req_ready), 32'd1);
         if (c == 4) begin
            chk("hold_accept_enable", 32'(bus.mem_enable), 32'd1);
            bus.req_valid = 1'b0;
         end
         if (c == int'(W) + 5) begin
            chk("hold_load_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_load_data", bus.resp_data, 32'hDEADBEEF);
         end
      end

      // Reset in the middle of a word store
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
      bus.req_addr = 32'd100; bus.req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("store_window_open", 32'(bus.mem_enable), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_enable", 32'(bus.mem_enable), 32'd0);
      chk("async_rst_rw", 32'(bus.mem_read_write), 32'd0);
      chk("async_rst_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      for (int i = 100; i < 104; i++) poke(i, 8'(i));
      do_req(1'b0, 2'b10, 1'b0, 32'd100, 32'd0, got);
      chk("post_rst_load", got, 32'h64656667);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         int unsigned r;
         bit [1:0]    sz;
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         do_req(1'($urandom), sz, 1'($urandom), $urandom, $urandom, got);
      end

      chk("rw_only_inside_window", 32'(rw_leak), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store controller that drives the 512-byte big-endian data RAM port (Enable, ReadWrite, SignExtend, Size, Address, DataIn/DataOut) on behalf of the MIPS pipeline. It accepts one load or store request at a time over a valid/ready handshake and holds a registered, glitch-free access window open on the level-sensitive RAM for a fixed number of cycles. It then returns read data, or a write acknowledge, as a one-cycle response pulse. Misalignment is checked before any RAM access is issued.

## Interface
- WAIT_CYCLES, 1: extra cycles the RAM enable window is held beyond the first; legal range 0–15.
- ADDR_W, 9: RAM address width.
- Clk  in  1  single clock; all state updates on rising edge.
- ResetN  in  1  reset, asynchronous and active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ReqSigned  in  1  sign-extend loaded byte or half.
- ReqAddr  in  32  byte address; bits above ADDR_W-1 ignored.
- ReqWData  in  32  store data, right-justified for byte and half.
- RespValid  out  1  one-cycle response pulse.
- RespData  out  32  load result; 0 for stores and errors.
- RespError  out  1  qualifies RespValid; illegal or misaligned request.
- MemEnable  out  1  RAM Enable.
- MemReadWrite  out  1  RAM ReadWrite (1 = write).
- MemSignExtend  out  1  RAM SignExtend.
- MemSize  out  2  RAM Size.
- MemAddress  out  ADDR_W  RAM Address.
- MemDataIn  out  32  data to RAM.
- MemDataOut  in  32  data from RAM.

## Operation
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE → ACCESS on ReqValid with a legal request. IDLE → ERR on ReqValid with an illegal request.
- ACCESS → RESP when the wait counter reaches WAIT_CYCLES. RESP → IDLE and ERR → IDLE unconditionally.
- On acceptance, all request fields are registered. The Mem* outputs are driven only from these registers, never combinationally from Req*.
- ACCESS: MemEnable=1. MemAddress, MemSize, MemSignExtend, MemDataIn and MemReadWrite stay constant for the whole window.
- Outside ACCESS: MemEnable=0 and MemReadWrite=0, so the RAM can never see a write strobe while idle.
- Load: MemDataOut is captured into RespData on the final ACCESS edge. The RAM performs all extension and byte lanes.
- Store: RespData=0.
- Illegal request: ReqSize=11 is always illegal; misalignment is also illegal when MISALIGN_TRAP_EN is defined. ERR produces no MemEnable and gives RespValid=1, RespError=1, RespData=0.
- The response channel has no backpressure; the consumer must accept RespValid when it occurs.
- Reset (any cycle, including mid-ACCESS): state returns to IDLE immediately. A store in flight is aborted, and the RAM contents for that store are undefined.
- Reset values: all outputs 0 except ReqReady, which is 1 once reset deasserts.

## Timing
- Request accepted at edge k (ReqValid & ReqReady).
- MemEnable is high from edge k to edge k+1+WAIT_CYCLES, i.e. for exactly WAIT_CYCLES+1 cycles.
- RespValid is high for the cycle after edge k+1+WAIT_CYCLES. Latency from accept to response is WAIT_CYCLES+2 cycles.
- Error path: RespValid is high for the cycle after edge k+1.
- ReqReady returns high in the cycle after RespValid. Minimum request spacing is WAIT_CYCLES+3 cycles.
- MemEnable and MemReadWrite fall on the same edge; address and data never change while MemEnable=1.

## Configuration
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half access at an odd address, or a word access with Address[1:0]≠00, goes to ERR.
- Undefined: the address low bits are forced to zero (half clears bit 0, word clears bits 1:0) and the access proceeds normally. No access can wrap past address 511 in either mode.

## Structure
- Package mem_access_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the FSM state enum;
  - the WAIT_CYCLES counter width constant.
- Sub-module mem_align_check: combinational; inputs size and address low bits; outputs the illegal flag and the aligned address.

## Test plan
- Pre-load RAM[16..19]=DE AD BE EF; word load at 16 with WAIT_CYCLES=1 → MemEnable high 2 cycles, RespData=DEADBEEF, RespValid 3 cycles after accept.
- Byte load at 17, ReqSigned=1 → RespData=FFFFFFAD; same with ReqSigned=0 → 000000AD.
- Half store 0x1234 at 40, then word load at 40 → first two bytes are 12 34; MemReadWrite is 0 whenever MemEnable is 0.
- Word load at 0x1F2 with the macro defined → RespError=1, MemEnable never asserted; without the macro → access goes to 0x1F0.
- ReqSize=11 → error response 2 cycles after accept; ReqValid held during RESP is not accepted until ReqReady=1.
- ResetN pulsed low mid-ACCESS of a word store → outputs 0 asynchronously; after release ReqReady=1 and a following load completes normally.
